lidar_obstacle_run_extractor: RTL and testbench
===============================================

// Module: lidar_obstacle_run_extractor
// PURPOSE
//   Downstream of lidar_ground_segmentation_top. Consumes the per-point
//   ground/obstacle stream plus the point's range. Groups consecutive obstacle
//   points, bridging short ground gaps, into runs. Emits one record per run
//   {start_r, end_r, len} through a small FIFO with a valid/ready output handshake.
//   Runs shorter than MIN_LEN are rejected as noise.
// PARAMETERS
//   DATA_WIDTH  16  width of range values (unsigned)
//   LEN_W       8   width of run_len; the count saturates at 2**LEN_W-1
//   MIN_LEN     3   minimum obstacle-point count for a run to be emitted (>=1)
//   GAP_MAX     2   max consecutive ground points tolerated inside a run (>=0)
//   FIFO_DEPTH  4   output FIFO entries (power of 2, >=2)
// PORTS
//   clk            in   1           system clock, rising edge
//   rst_n          in   1           asynchronous active-low reset
//   seg_valid_in   in   1           segmentation_result/seg_r_in valid this cycle
//   seg_ground_in  in   1           1 = ground, 0 = obstacle (from segmentation_result)
//   seg_r_in       in   DATA_WIDTH  range of the classified point
//   scan_end_in    in   1           end-of-scan pulse: force-close any open run
//   run_ready_in   in   1           consumer accepts the head record
//   run_valid      out  1           head record available
//   run_start_r    out  DATA_WIDTH  range of the first obstacle point in the run
//   run_end_r      out  DATA_WIDTH  range of the last obstacle point in the run
//   run_len        out  LEN_W       obstacle points in the run; gap points not counted
//   overflow       out  1           sticky: a qualifying record was dropped (FIFO full)
// BEHAVIOUR
//   - Reset (async, rst_n=0): state GROUND, counters 0, FIFO empty. run_valid=0,
//     run_start_r=0, run_end_r=0, run_len=0, overflow=0. An open run is discarded.
//   - The input has no backpressure. Every seg_valid_in cycle is consumed.
//   - FSM updates only when seg_valid_in=1, except for the scan_end_in close:
//     GROUND: obstacle -> RUN; start_r=end_r=r, len=1, gap=0. ground -> stay.
//     RUN:    obstacle -> end_r=r, len+1 (saturating).
//             ground   -> GAP_MAX=0 ? close, GROUND : GAP, gap=1.
//     GAP:    obstacle -> RUN; end_r=r, len+1, gap=0.
//             ground   -> gap==GAP_MAX ? close, GROUND : gap+1.
//   - scan_end_in=1: the same-cycle valid sample is processed first. Then any open
//     run (RUN/GAP, including one opened this cycle) is closed; next state GROUND.
//     scan_end_in in GROUND with no run has no effect.
//   - Close: if len>=MIN_LEN, push {start_r,end_r,len}. Otherwise discard silently.
//     The record is never merged or split.
//   - Push occurs on the clock edge that consumes the closing sample or scan_end.
//     If the FIFO was empty, run_valid rises the next cycle (1-cycle latency).
//   - Output handshake: pop when run_valid&&run_ready_in. While run_valid=1 and not
//     popped, run_* hold stable. When the FIFO is empty, run_* hold their last
//     values and run_valid=0.
//   - Full FIFO with a push and no pop: record dropped; overflow set (reset clears).
//     Full FIFO with a push and a pop in the same cycle: both occur; no drop.
//     Empty FIFO with a push and run_ready_in=1: no bypass; the pop happens next cycle.
//   - Pointers wrap modulo FIFO_DEPTH. An occupancy counter of log2(DEPTH)+1 bits
//     distinguishes full from empty.
//   - Range values are unsigned and copied verbatim; no monotonicity check on seg_r_in.
// TESTING
//   1 Flat/obstacle/flat: 15 ground r=10..150, 10 obstacle r=160..250, 15 ground
//     r=260..400 (defaults) -> one record {160,250,10}. run_valid rises the cycle
//     after the r=280 sample. No further records.
//   2 Gap bridging: obstacle r=10,20, ground r=30,40, obstacle r=50, then 3 ground
//     -> one record {10,50,3}. With 3 ground at r=30..50 instead -> the {10,20}
//     run is discarded (len 2<MIN_LEN) and no record is emitted.
//   3 Scan end: obstacle r=100,110,120 with scan_end_in on the r=120 cycle
//     -> record {100,120,3} next cycle; FSM back in GROUND.
//   4 Backpressure/overflow: run_ready_in=0; produce 5 qualifying runs -> 4 stored,
//     5th dropped, overflow=1. Then ready=1 -> 4 records in order, then run_valid=0.
//   5 Full + simultaneous push/pop: FIFO full, run_ready_in=1 on the closing edge
//     -> no drop, overflow stays 0.
//   6 Reset mid-run and saturation: assert rst_n=0 inside a run -> all outputs 0,
//     no record. A 300-point run (LEN_W=8) -> run_len=255.

Source files
------------

// File: rtl/lidar_obstacle_run_extractor.sv
// lidar_obstacle_run_extractor: groups obstacle points (bridging short ground gaps)
// into runs and queues {start_r, end_r, len} records behind a valid/ready FIFO.
module lidar_obstacle_run_extractor #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 8,
  parameter int MIN_LEN    = 3,
  parameter int GAP_MAX    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seg_valid_in,
  input  logic                  seg_ground_in,
  input  logic [DATA_WIDTH-1:0] seg_r_in,
  input  logic                  scan_end_in,
  input  logic                  run_ready_in,
  output logic                  run_valid,
  output logic [DATA_WIDTH-1:0] run_start_r,
  output logic [DATA_WIDTH-1:0] run_end_r,
  output logic [LEN_W-1:0]      run_len,
  output logic                  overflow
);
  localparam int GW = $clog2(GAP_MAX + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 2 * DATA_WIDTH + LEN_W;
  localparam logic [LEN_W-1:0] MIN_L  = LEN_W'(MIN_LEN);
  localparam logic [GW-1:0]    GAP_L  = GW'(GAP_MAX);
  localparam logic [CW-1:0]    FULL_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {GROUND, RUN, GAP} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] start_q, start_n, end_q, end_n;
  logic [LEN_W-1:0]      len_q, len_n, len_inc;
  logic [GW-1:0]         gap_q, gap_n;
  logic                  obs, grd, close, push, pop, full, wr_en;
  logic [RW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [RW-1:0]         last_q;

  assign obs     = seg_valid_in && !seg_ground_in;
  assign grd     = seg_valid_in && seg_ground_in;
  assign len_inc = &len_q ? len_q : len_q + 1'b1;

  always_comb begin
    state_n = state;
    start_n = start_q;
    end_n   = end_q;
    len_n   = len_q;
    gap_n   = gap_q;
    close   = 1'b0;
    case (state)
      GROUND: if (obs) begin
        state_n = RUN;
        start_n = seg_r_in;
        end_n   = seg_r_in;
        len_n   = LEN_W'(1);
        gap_n   = '0;
      end
      RUN: if (obs) begin
        end_n = seg_r_in;
        len_n = len_inc;
      end else if (grd) begin
        if (GAP_MAX == 0) begin
          close   = 1'b1;
          state_n = GROUND;
        end else begin
          state_n = GAP;
          gap_n   = GW'(1);
        end
      end
      GAP: if (obs) begin
        state_n = RUN;
        end_n   = seg_r_in;
        len_n   = len_inc;
        gap_n   = '0;
      end else if (grd) begin
        if (gap_q == GAP_L) begin
          close   = 1'b1;
          state_n = GROUND;
        end else begin
          gap_n = gap_q + 1'b1;
        end
      end
      default: state_n = GROUND;
    endcase
    // scan end closes whatever is still open after this cycle's sample
    if (scan_end_in && state_n != GROUND) begin
      close   = 1'b1;
      state_n = GROUND;
    end
  end

  assign push      = close && len_n >= MIN_L;
  assign run_valid = count != '0;
  assign pop       = run_valid && run_ready_in;
  assign full      = count == FULL_C;
  assign wr_en     = push && (!full || pop);
  assign {run_start_r, run_end_r, run_len} = run_valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GROUND;
      start_q  <= '0;
      end_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_q   <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_n;
      start_q <= start_n;
      end_q   <= end_n;
      len_q   <= len_n;
      gap_q   <= gap_n;
      count   <= count + CW'(wr_en) - CW'(pop);
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {start_n, end_n, len_n};
  end
endmodule

// File: tb/tb_lidar_obstacle_run_extractor.sv
// tb_lidar_obstacle_run_extractor: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of runs and the output FIFO.
module tb_lidar_obstacle_run_extractor;
  localparam int DW = 16, LW = 8, MINL = 3, GMAX = 2, DEPTH = 4;
  typedef struct packed {logic [DW-1:0] s; logic [DW-1:0] e; logic [LW-1:0] l;} rec_t;

  logic clk = 0, rst_n = 0, seg_valid_in = 0, seg_ground_in = 0, scan_end_in = 0, run_ready_in = 0;
  logic [DW-1:0] seg_r_in = 0;
  logic run_valid, overflow;
  logic [DW-1:0] run_start_r, run_end_r;
  logic [LW-1:0] run_len;
  int checks = 0, errors = 0, pops = 0;

  lidar_obstacle_run_extractor dut (
    .clk(clk), .rst_n(rst_n), .seg_valid_in(seg_valid_in), .seg_ground_in(seg_ground_in),
    .seg_r_in(seg_r_in), .scan_end_in(scan_end_in), .run_ready_in(run_ready_in),
    .run_valid(run_valid), .run_start_r(run_start_r), .run_end_r(run_end_r),
    .run_len(run_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // model: obstacle ranges of the open run, trailing ground streak, output queue
  logic [DW-1:0] run_q[$];
  int streak;
  rec_t mq[$];
  rec_t last;
  logic ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q.delete(); streak = 0; mq.delete(); last = '0; ovf = 0;
    end else begin
      bit m_pop, m_full, have;
      rec_t nr;
      m_full = mq.size() == DEPTH;
      m_pop  = mq.size() > 0 && run_ready_in;
      have   = 0;
      nr     = '0;
      if (seg_valid_in) begin
        if (!seg_ground_in) begin run_q.push_back(seg_r_in); streak = 0; end
        else if (run_q.size() > 0) streak++;
      end
      if (run_q.size() > 0 && (streak > GMAX || scan_end_in)) begin
        if (run_q.size() >= MINL) begin
          have = 1;
          nr.s = run_q[0];
          nr.e = run_q[$];
          nr.l = run_q.size() > 255 ? 8'd255 : LW'(run_q.size());
        end
        run_q.delete(); streak = 0;
      end
      if (m_pop) last = mq.pop_front();
      if (have) begin
        if (m_full && !m_pop) ovf = 1;
        else mq.push_back(nr);
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    rec_t h;
    h = mq.size() > 0 ? mq[0] : last;
    chk("valid", 64'(run_valid), 64'(mq.size() > 0));
    chk("start_r", 64'(run_start_r), 64'(h.s));
    chk("end_r", 64'(run_end_r), 64'(h.e));
    chk("len", 64'(run_len), 64'(h.l));
    chk("overflow", 64'(overflow), 64'(ovf));
    if (run_valid && run_ready_in) pops++;
  end

  task automatic send(input logic g, input logic [DW-1:0] r, input logic se = 0);
    seg_valid_in = 1; seg_ground_in = g; seg_r_in = r; scan_end_in = se;
    @(posedge clk); #1;
    seg_valid_in = 0; scan_end_in = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) send(0, base + DW'(i));
    for (int i = 0; i < 3; i++) send(1, base + DW'(n + i));
  endtask

  task automatic reset_now();
    rst_n = 0; #1;
    chk("rst_valid", 64'(run_valid), 64'd0);
    chk("rst_start", 64'(run_start_r), 64'd0);
    chk("rst_end", 64'(run_end_r), 64'd0);
    chk("rst_len", 64'(run_len), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    @(posedge clk); #1;
    reset_now();
    // flat / obstacle / flat
    run_ready_in = 1; pops = 0;
    for (int i = 1; i <= 25; i++) send(i > 15 ? 1'b0 : 1'b1, DW'(10 * i));
    send(1, 260); send(1, 270);
    chk("t1_pre_valid", 64'(run_valid), 64'd0);
    send(1, 280);
    chk("t1_valid", 64'(run_valid), 64'd1);
    chk("t1_start", 64'(run_start_r), 64'd160);
    chk("t1_end", 64'(run_end_r), 64'd250);
    chk("t1_len", 64'(run_len), 64'd10);
    chk("t1_model", 64'(mq.size() == 1 && mq[0] == rec_t'{16'd160, 16'd250, 8'd10}), 64'd1);
    for (int i = 29; i <= 40; i++) send(1, DW'(10 * i));
    chk("t1_after_valid", 64'(run_valid), 64'd0);
    chk("t1_pops", 64'(pops), 64'd1);
    // gap bridging
    run_ready_in = 0;
    send(0, 10); send(0, 20); send(1, 30); send(1, 40); send(0, 50);
    send(1, 60); send(1, 70); send(1, 80);
    chk("t2_valid", 64'(run_valid), 64'd1);
    chk("t2_start", 64'(run_start_r), 64'd10);
    chk("t2_end", 64'(run_end_r), 64'd50);
    chk("t2_len", 64'(run_len), 64'd3);
    run_ready_in = 1; idle(1); run_ready_in = 0;
    send(0, 10); send(0, 20); send(1, 30); send(1, 40); send(1, 50); idle(2);
    chk("t2b_valid", 64'(run_valid), 64'd0);
    chk("t2b_model", 64'(mq.size()), 64'd0);
    // scan end
    send(0, 100); send(0, 110); send(0, 120, 1);
    chk("t3_valid", 64'(run_valid), 64'd1);
    chk("t3_rec", 64'({run_start_r, run_end_r, run_len}), 64'({16'd100, 16'd120, 8'd3}));
    run_ready_in = 1; idle(1); run_ready_in = 0;
    send(0, 200); send(1, 210); send(1, 220); send(1, 230);
    chk("t3_ground_after", 64'(run_valid), 64'd0);
    // overflow
    for (int k = 0; k < 5; k++) run(DW'(1000 + 100 * k), 3);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_head", 64'(run_start_r), 64'd1000);
    pops = 0; run_ready_in = 1; idle(6); run_ready_in = 0;
    chk("t4_valid", 64'(run_valid), 64'd0);
    chk("t4_pops", 64'(pops), 64'd4);
    chk("t4_last_end", 64'(run_end_r), 64'd1302);
    // full with simultaneous push and pop
    reset_now();
    for (int k = 0; k < 4; k++) run(DW'(2000 + 100 * k), 3);
    send(0, 2400); send(0, 2401); send(0, 2402); send(1, 2403); send(1, 2404);
    run_ready_in = 1; send(1, 2405); run_ready_in = 0;
    chk("t5_ovf", 64'(overflow), 64'd0);
    chk("t5_head", 64'(run_start_r), 64'd2100);
    run_ready_in = 1; idle(6); run_ready_in = 0;
    chk("t5_valid", 64'(run_valid), 64'd0);
    chk("t5_hold_end", 64'(run_end_r), 64'd2402);
    // reset mid-run
    run(3000, 3);
    send(0, 3100); send(0, 3101); send(0, 3102);
    reset_now();
    send(1, 3103); send(1, 3104); send(1, 3105); idle(2);
    chk("t6_valid", 64'(run_valid), 64'd0);
    chk("t6_len", 64'(run_len), 64'd0);
    // saturation
    for (int i = 0; i < 300; i++) send(0, DW'(4000 + i));
    send(1, 1); send(1, 2); send(1, 3);
    chk("t6_sat_valid", 64'(run_valid), 64'd1);
    chk("t6_sat_len", 64'(run_len), 64'd255);
    chk("t6_sat_start", 64'(run_start_r), 64'd4000);
    chk("t6_sat_end", 64'(run_end_r), 64'd4299);
    run_ready_in = 1; idle(2); run_ready_in = 0;
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      seg_valid_in  = $urandom_range(0, 3) != 0;
      seg_ground_in = $urandom_range(0, 9) < 4;
      seg_r_in      = DW'($urandom);
      scan_end_in   = $urandom_range(0, 39) == 0;
      run_ready_in  = i % 1000 < 300 ? 1'b0 : $urandom_range(0, 9) < 6;
      @(posedge clk); #1;
    end
    seg_valid_in = 0; scan_end_in = 0; run_ready_in = 1;
    idle(8);
    chk("rand_drained", 64'(run_valid), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
